// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Each rank resolves STAGE_GROUPS 4-bit CLA groups and hands its carry to the next rank.
module cla_adder_pipe #(
  parameter int WIDTH        = 16,
  parameter int STAGE_GROUPS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             C0_in,
  input  logic             SUB_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] S_out,
  output logic             C_out,
  output logic             V_out,
  output logic             Z_out
);

  localparam int NSTAGE = WIDTH / (4 * STAGE_GROUPS);
  localparam int LAST   = NSTAGE - 1;

  if ((WIDTH % (4 * STAGE_GROUPS)) != 0 || NSTAGE < 1) begin : g_bad_width
    $error("cla_adder_pipe: WIDTH must be a nonzero multiple of 4*STAGE_GROUPS");
  end

  // Handshake: a beat moves across an interface on a rising edge where valid
  // and ready are both high; valid_out/S_out/flags hold while valid_out && !ready_in.

  // Returns {carry into bit 3, carry out, sum[3:0]} of one lookahead group.
  function automatic logic [5:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c[3], c[4], p ^ c[3:0]};
  endfunction

  logic [NSTAGE-1:0] v_q;
  logic [NSTAGE-1:0] c_q;
  logic [WIDTH-1:0]  a_q [NSTAGE];
  logic [WIDTH-1:0]  b_q [NSTAGE];
  logic [WIDTH-1:0]  s_q [NSTAGE];
  logic              v_flag_q;
  logic              z_flag_q;

  logic [NSTAGE-1:0] load;
  logic [NSTAGE-1:0] nxt_c;
  logic [WIDTH-1:0]  in_a  [NSTAGE];
  logic [WIDTH-1:0]  in_b  [NSTAGE];
  logic [WIDTH-1:0]  nxt_s [NSTAGE];
  logic              c_top;
  logic              stall;
  logic              carry;
  logic [5:0]        grp;
  int                idx;

  assign stall     = v_q[LAST] && !ready_in;
  assign ready_out = !stall;

  always_comb begin
    load  = '0;
    nxt_c = '0;
    c_top = 1'b0;
    carry = 1'b0;
    grp   = '0;
    idx   = 0;
    for (int k = 0; k < NSTAGE; k++) begin
      if (k == 0) begin
        load[k]  = valid_in;
        in_a[k]  = A_in;
        in_b[k]  = SUB_in ? ~B_in : B_in;
        nxt_s[k] = '0;
        carry    = SUB_in | C0_in;
      end else begin
        load[k]  = v_q[k-1];
        in_a[k]  = a_q[k-1];
        in_b[k]  = b_q[k-1];
        nxt_s[k] = s_q[k-1];
        carry    = c_q[k-1];
      end
      // Group carries ripple across the groups owned by this rank.
      for (int g = 0; g < STAGE_GROUPS; g++) begin
        idx                = (k * STAGE_GROUPS + g) * 4;
        grp                = cla4(in_a[k][idx +: 4], in_b[k][idx +: 4], carry);
        nxt_s[k][idx +: 4] = grp[3:0];
        carry              = grp[4];
        c_top              = grp[5];
      end
      nxt_c[k] = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q      <= '0;
      c_q      <= '0;
      v_flag_q <= 1'b0;
      z_flag_q <= 1'b0;
      for (int k = 0; k < NSTAGE; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (!stall) begin
      v_q <= load;
      // Data registers only move with a real beat so idle outputs keep their last value.
      for (int k = 0; k < NSTAGE; k++) begin
        if (load[k]) begin
          a_q[k] <= in_a[k];
          b_q[k] <= in_b[k];
          s_q[k] <= nxt_s[k];
          c_q[k] <= nxt_c[k];
        end
      end
      if (load[LAST]) begin
        v_flag_q <= c_top ^ nxt_c[LAST];
        z_flag_q <= (nxt_s[LAST] == '0);
      end
    end
  end

  assign valid_out = v_q[LAST];
  assign S_out     = s_q[LAST];
  assign C_out     = c_q[LAST];
  assign V_out     = v_flag_q;
  assign Z_out     = z_flag_q;

endmodule
